// File: rtl/rs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rs_pkg
// Purpose  : Shared Reed-Solomon field constants and key-equation FSM states.
// Revision : 1.0  initial release
// ============================================================================
package rs_pkg;

  localparam int         C_RS_M         = 8;
  localparam logic [8:0] C_RS_PRIM_POLY = 9'h11D;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DISC = 2'd1,
    UPDT = 2'd2,
    DONE = 2'd3
  } bm_state_e;

endpackage
`default_nettype wire

// File: rtl/rs_bm_sigma_if.sv
`default_nettype none
// ============================================================================
// Module   : rs_bm_sigma_if
// Purpose  : Job request / locator result bundle of the Berlekamp-Massey block.
// Revision : 1.0  initial release
// ============================================================================
interface rs_bm_sigma_if
  import rs_pkg::*;
#(
  parameter int T = 3,
  parameter int M = C_RS_M
);

  logic                         start;
  logic [2*T*M-1:0]             syn_in;
  logic                         busy;
  logic                         done;
  logic [(T+1)*M-1:0]           sigma_out;
  logic [$clog2(2*T+1)-1:0]     deg_out;
  logic                         fail;

  modport master (output start, syn_in, input busy, done, sigma_out, deg_out, fail);
  modport slave  (input start, syn_in, output busy, done, sigma_out, deg_out, fail);

endinterface
`default_nettype wire

// File: rtl/gf_mul.sv
`default_nettype none
// ============================================================================
// Module   : gf_mul
// Purpose  : Combinational GF(2^M) multiplier, reduced modulo PRIM_POLY.
// Revision : 1.0  initial release
// ============================================================================
module gf_mul #(
  parameter int         M         = 8,
  parameter logic [M:0] PRIM_POLY = 9'h11D
) (
  input  wire logic [M-1:0] i_a,
  input  wire logic [M-1:0] i_b,
  output logic      [M-1:0] o_p
);

  logic [M-1:0] w_acc;

  // Horner form: multiply accumulator by x, reduce, then add a when b bit set.
  always_comb begin
    w_acc = '0;
    for (int i = M - 1; i >= 0; i--) begin
      w_acc = {w_acc[M-2:0], 1'b0} ^ ({M{w_acc[M-1]}} & PRIM_POLY[M-1:0]);
      if (i_b[i]) w_acc = w_acc ^ i_a;
    end
    o_p = w_acc;
  end

endmodule
`default_nettype wire

// File: rtl/rs_bm_sigma.sv
`default_nettype none
// ============================================================================
// Module   : rs_bm_sigma
// Purpose  : Inversionless Berlekamp-Massey solver producing the error locator.
// Revision : 1.0  initial release
// ============================================================================
module rs_bm_sigma
  import rs_pkg::*;
#(
  parameter int         T         = 3,
  parameter int         M         = C_RS_M,
  parameter logic [M:0] PRIM_POLY = (M+1)'(C_RS_PRIM_POLY)
) (
  input wire logic      clk,
  input wire logic      rst_n,
  rs_bm_sigma_if.slave  bus
);

  localparam int C_LW = $clog2(2*T+1);
  localparam int C_RW = $clog2(2*T);
  localparam logic [T:0][M-1:0]   C_ONE   = ((T+1)*M)'(1);
  localparam logic [T-1:0][M-1:0] C_ONE_B = (T*M)'(1);

  bm_state_e                r_state, w_state_nx;
  logic [2*T-1:0][M-1:0]    r_syn;
  logic [T:0][M-1:0]        r_sigma, r_sigma_out;
  logic [T-1:0][M-1:0]      r_b;
  logic [M-1:0]             r_gamma, r_d;
  logic [C_LW-1:0]          r_l, r_deg;
  logic [C_RW-1:0]          r_r;
  logic                     r_fail;

  logic [T:0][M-1:0]        w_syn_sel, w_dprod, w_gs, w_db, w_xb, w_sigma_nx;
  logic [M-1:0]             w_d_nx;
  logic [C_LW-1:0]          w_l_nx, w_l_fin;
  logic                     w_swap, w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nx = DISC;
      DISC:    w_state_nx = UPDT;
      UPDT:    w_state_nx = w_last ? DONE : DISC;
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // Syndrome S(r+1-j) feeding coefficient j; indices below S1 contribute zero.
  always_comb begin
    w_syn_sel = '0;
    for (int j = 0; j <= T; j++)
      if (r_r >= C_RW'(j)) w_syn_sel[j] = r_syn[r_r - C_RW'(j)];
  end

  always_comb begin
    w_d_nx = '0;
    for (int j = 0; j <= T; j++) w_d_nx = w_d_nx ^ w_dprod[j];
  end

  for (genvar j = 0; j <= T; j++) begin : g_coef
    gf_mul #(.M(M), .PRIM_POLY(PRIM_POLY)) u_disc  (.i_a(r_sigma[j]), .i_b(w_syn_sel[j]), .o_p(w_dprod[j]));
    gf_mul #(.M(M), .PRIM_POLY(PRIM_POLY)) u_scale (.i_a(r_gamma),    .i_b(r_sigma[j]),   .o_p(w_gs[j]));
    gf_mul #(.M(M), .PRIM_POLY(PRIM_POLY)) u_corr  (.i_a(r_d),        .i_b(w_xb[j]),      .o_p(w_db[j]));
  end

  assign w_xb       = {r_b, {M{1'b0}}};
  assign w_sigma_nx = w_gs ^ w_db;
  assign w_last     = (r_r == C_RW'(2*T-1));
  assign w_swap     = (r_d != '0) && ({r_l, 1'b0} <= (C_LW+1)'(r_r));
  assign w_l_nx     = C_LW'(r_r) + C_LW'(1) - r_l;
  assign w_l_fin    = w_swap ? w_l_nx : r_l;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_syn       <= '0;
      r_sigma     <= C_ONE;
      r_b         <= '0;
      r_gamma     <= '0;
      r_d         <= '0;
      r_l         <= '0;
      r_r         <= '0;
      r_sigma_out <= C_ONE;
      r_deg       <= '0;
      r_fail      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_syn   <= bus.syn_in;
          r_sigma <= C_ONE;
          r_b     <= C_ONE_B;
          r_gamma <= M'(1);
          r_l     <= '0;
          r_r     <= '0;
        end
        DISC: r_d <= w_d_nx;
        UPDT: begin
          r_sigma <= w_sigma_nx;
          r_r     <= r_r + C_RW'(1);
          if (w_swap) begin
            r_b     <= r_sigma[T-1:0];
            r_l     <= w_l_nx;
            r_gamma <= r_d;
          end else begin
            r_b     <= w_xb[T-1:0];
          end
          // Results are published as the machine enters DONE so they are valid with done.
          if (w_last) begin
            r_sigma_out <= w_sigma_nx;
            r_deg       <= w_l_fin;
            r_fail      <= (w_l_fin > C_LW'(T));
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (r_state == DISC) || (r_state == UPDT);
  assign bus.done      = (r_state == DONE);
  assign bus.sigma_out = r_sigma_out;
  assign bus.deg_out   = r_deg;
  assign bus.fail      = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_rs_bm_sigma.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_bm_sigma
// Purpose  : Randomised self-checking bench against a textbook BM model.
// Revision : 1.0  initial release
// ============================================================================
module tb_rs_bm_sigma;

  localparam int C_T   = 3;
  localparam int C_LAT = 4*C_T + 1;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   prev_deg = 0;
  bit   prev_valid = 1'b1;
  int   ref_l;
  logic [7:0] ref_c [0:6];

  always #5 clk = ~clk;

  rs_bm_sigma_if #(.T(C_T), .M(8)) bus ();

  rs_bm_sigma #(.T(C_T), .M(8), .PRIM_POLY(9'h11D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Schoolbook product followed by polynomial reduction.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11D << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] gpow(input int k);
    logic [7:0] r = 8'h01;
    for (int i = 0; i < (k % 255); i++) r = gmul(r, 8'h02);
    return r;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r = '0;
    for (int v = 1; v < 256; v++) if (gmul(a, 8'(v)) == 8'h01) r = 8'(v);
    return r;
  endfunction

  function automatic logic [47:0] rand_syn();
    return 48'({$urandom(), $urandom()});
  endfunction

  function automatic logic [47:0] err_syn(input int nerr);
    int pos [0:3];
    logic [7:0] ev [0:3];
    logic [7:0] acc;
    logic [47:0] syn = '0;
    bit dup;
    for (int k = 0; k < nerr; k++) begin
      do begin
        pos[k] = int'($urandom_range(0, 254));
        dup = 1'b0;
        for (int q = 0; q < k; q++) if (pos[q] == pos[k]) dup = 1'b1;
      end while (dup);
      ev[k] = 8'($urandom_range(1, 255));
    end
    for (int i = 1; i <= 6; i++) begin
      acc = '0;
      for (int k = 0; k < nerr; k++) acc = acc ^ gmul(ev[k], gpow(i * pos[k]));
      syn[8*(i-1) +: 8] = acc;
    end
    return syn;
  endfunction

  // Classic Massey algorithm with field division, untruncated polynomials.
  task automatic ref_bm(input logic [7:0] s [0:5]);
    logic [7:0] c [0:6];
    logic [7:0] b [0:6];
    logic [7:0] tmp [0:6];
    logic [7:0] d, bb, coef;
    int l, m;
    c = '{default: 8'h00}; b = '{default: 8'h00};
    c[0] = 8'h01; b[0] = 8'h01; bb = 8'h01; l = 0; m = 1;
    for (int n = 0; n < 6; n++) begin
      d = s[n];
      for (int i = 1; i <= l; i++) d = d ^ gmul(c[i], s[n-i]);
      if (d == 8'h00) m++;
      else begin
        coef = gmul(d, ginv(bb));
        tmp = c;
        for (int i = 0; i + m <= 6; i++) c[i+m] = c[i+m] ^ gmul(coef, b[i]);
        if (2*l <= n) begin
          l = n + 1 - l; b = tmp; bb = d; m = 1;
        end else m++;
      end
    end
    ref_l = l;
    ref_c = c;
  endtask

  task automatic check_result(input logic [47:0] syn, input int nerr, input string tag);
    logic [7:0] s [0:5];
    logic [31:0] so;
    logic [7:0] inv;
    for (int n = 0; n < 6; n++) s[n] = syn[8*n +: 8];
    ref_bm(s);
    check_eq({tag, "_fail"}, 32'(bus.fail), 32'(ref_l > C_T));
    if (nerr >= 0 && nerr <= C_T) check_eq({tag, "_deg_vs_errs"}, 32'(bus.deg_out), 32'(nerr));
    if (ref_l <= C_T) begin
      check_eq({tag, "_deg"}, 32'(bus.deg_out), 32'(ref_l));
      so = bus.sigma_out;
      check_eq({tag, "_s0_nonzero"}, 32'(so[7:0] != 8'h00), 32'd1);
      inv = ginv(so[7:0]);
      for (int j = 0; j <= C_T; j++)
        check_eq($sformatf("%s_coef%0d", tag, j), 32'(gmul(so[8*j +: 8], inv)), 32'(ref_c[j]));
      prev_deg = ref_l; prev_valid = 1'b1;
    end else begin
      check_eq({tag, "_deg_gt_t"}, 32'(bus.deg_out > 3'(C_T)), 32'd1);
      prev_valid = 1'b0;
    end
  endtask

  // Entered and left at posedge+1 with the DUT idle; start is toggled randomly while busy.
  task automatic run_job(input logic [47:0] syn, input int nerr, input string tag);
    int cyc = 0;
    bus.start = 1'b1; bus.syn_in = syn;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.syn_in = rand_syn();
    while (1) begin
      @(negedge clk); cyc++;
      if (cyc == 1) check_eq({tag, "_busy"}, 32'(bus.busy), 32'd1);
      if (cyc == 6 && prev_valid) check_eq({tag, "_deg_hold"}, 32'(bus.deg_out), 32'(prev_deg));
      if (bus.done) break;
      if (cyc >= 40) begin
        check_eq({tag, "_timeout"}, 32'(cyc), 32'(C_LAT));
        break;
      end
      bus.start = 1'($urandom_range(0, 1)); bus.syn_in = rand_syn();
    end
    check_eq({tag, "_latency"}, 32'(cyc), 32'(C_LAT));
    check_result(syn, nerr, tag);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_eq({tag, "_done_low"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    logic [47:0] acc_syn [0:2];
    logic [47:0] sy;
    bus.start = 1'b0; bus.syn_in = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy",  32'(bus.busy), 32'd0);
    check_eq("rst_done",  32'(bus.done), 32'd0);
    check_eq("rst_sigma", 32'(bus.sigma_out), 32'h1);
    check_eq("rst_deg",   32'(bus.deg_out), 32'd0);
    check_eq("rst_fail",  32'(bus.fail), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    run_job('0, 0, "zero");
    check_eq("zero_sigma_exact", 32'(bus.sigma_out), 32'h1);
    run_job({6{8'h01}}, 1, "ones");
    check_eq("ones_sigma_exact", 32'(bus.sigma_out), 32'h0000_0101);

    for (int k = 0; k < 6; k++) begin
      int ne = (k % 3) + 1;
      run_job(err_syn(ne), ne, $sformatf("err%0d_%0d", ne, k));
    end
    run_job(err_syn(4), 4, "err4");
    for (int k = 0; k < 3; k++) run_job(rand_syn(), -1, $sformatf("rnd_%0d", k));

    // Abort a run partway through with an asynchronous reset.
    bus.start = 1'b1; bus.syn_in = err_syn(2);
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_busy",  32'(bus.busy), 32'd0);
    check_eq("abort_done",  32'(bus.done), 32'd0);
    check_eq("abort_sigma", 32'(bus.sigma_out), 32'h1);
    check_eq("abort_deg",   32'(bus.deg_out), 32'd0);
    check_eq("abort_fail",  32'(bus.fail), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      check_eq("abort_no_done", 32'(bus.done), 32'd0);
    end
    @(posedge clk); #1;
    prev_deg = 0; prev_valid = 1'b1;
    run_job(err_syn(3), 3, "post_rst");

    // Start held high: acceptance every 4T+2 cycles, each with its own syndromes.
    bus.start = 1'b1;
    for (int c = 0; c < 42; c++) begin
      sy = rand_syn();
      bus.syn_in = sy;
      if (c % 14 == 0) acc_syn[c/14] = sy;
      @(posedge clk);
      @(negedge clk);
      check_eq($sformatf("b2b_done_c%0d", c + 1), 32'(bus.done), 32'((c + 1) % 14 == 13));
      if ((c + 1) % 14 == 13) check_result(acc_syn[(c+1)/14], -1, $sformatf("b2b_%0d", (c+1)/14));
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    check_eq("b2b_idle_busy", 32'(bus.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rs_bm_sigma.md
RS_BM_SIGMA -- requirements
Module: rs_bm_sigma

Interface
REQ-001 Parameter T, default 3: correctable symbol count; 2T syndromes in, degree-T locator out.
REQ-002 Parameter M, default 8: GF(2^M) symbol width.
REQ-003 Parameter PRIM_POLY, default 9'h11D: field primitive polynomial, M+1 bits.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  one-cycle request; sampled only in IDLE.
REQ-007 syn_in  in  2T*M  syndromes S1..S2T packed, S1 in bits [M-1:0].
REQ-008 busy  out  1  high from the cycle after start acceptance until done.
REQ-009 done  out  1  one-cycle pulse; results valid.
REQ-010 sigma_out  out  (T+1)*M  locator coefficients sigma0..sigmaT, sigma0 in LSBs; held until next acceptance.
REQ-011 deg_out  out  $clog2(2T+1)  final register length L.
REQ-012 fail  out  1  L > T at completion (uncorrectable); valid with done, held.

Function
REQ-013 Algorithm: inversionless Berlekamp-Massey over GF(2^M); sigma_out is a nonzero scalar multiple of the normalised locator; no GF inverse hardware.
REQ-014 FSM states IDLE, DISC, UPDT, DONE; IDLE->DISC on start; DISC->UPDT always; UPDT->DISC while r<2T-1, else ->DONE; DONE->IDLE after one cycle.
REQ-015 On acceptance: latch syn_in, sigma=1, B=1, gamma=1, L=0, r=0.
REQ-016 DISC: register d = XOR over j=0..T of sigma_j*S(r+1-j); terms with S index <1 treated as zero.
REQ-017 UPDT: sigma <= gamma*sigma XOR d*(x*B); x*B shifts up one coefficient, degree-T+1 term dropped.
REQ-018 UPDT, d!=0 and 2L<=r: B<=old sigma, L<=r+1-L, gamma<=d; otherwise B<=x*B, L and gamma unchanged; r<=r+1.
REQ-019 Latency: done asserts exactly 4T+1 cycles after the start-sampling edge (13 for T=3).
REQ-020 start while busy or in DONE is ignored; latched syndromes unaffected.
REQ-021 start coincident with done is ignored; start in the next cycle (IDLE) is accepted: back-to-back throughput 4T+2 cycles.
REQ-022 sigma_out, deg_out, fail update only in DONE, stable otherwise; all-zero syndromes yield sigma_out=1, deg_out=0, fail=0.
REQ-023 fail = (L > T); deg_out reports true L even when fail.
REQ-024 All GF arithmetic width M, XOR addition, multiplication reduced mod PRIM_POLY.

Reset
REQ-025 rst_n low asynchronously forces IDLE, busy=0, done=0, fail=0, deg_out=0, sigma_out=1 (sigma0=1, others 0), internal r/L/gamma/B/d cleared.
REQ-026 Reset mid-computation aborts with no done pulse; first start after rst_n release is accepted normally.

Structure
REQ-027 Shared package rs_pkg holds M, PRIM_POLY default, and the gf_mul function prototype constants; reused by syndrome and Chien blocks.
REQ-028 One sub-module gf_mul (combinational M-bit GF multiplier, parameter PRIM_POLY); instantiated (T+1) for discrepancy and 2(T+1) for update, no other hierarchy.
REQ-029 No latches, no multicycle paths; discrepancy XOR tree depth log2(T+1).

Verification
REQ-030 T=3, syndromes all 0, start -> done at cycle 13, sigma_out={1,0,0,0}, deg_out=0, fail=0.
REQ-031 T=3, S1..S6 all 1 (error value 1 at position 0) -> sigma_out={1,1,0,0}, deg_out=1, fail=0.
REQ-032 T=3, syndromes from 2 and 3 random errors of a reference codeword -> sigma_out roots (Chien model) equal alpha^-i of injected positions, deg_out matches error count.
REQ-033 T=3, 4-error pattern -> fail=1 or locator inconsistent with model; deg_out>3 flags fail.
REQ-034 rst_n pulsed low at cycle 6 of a run -> outputs at reset values immediately, no done; fresh start afterwards completes in 13 cycles with correct result.
REQ-035 start held high continuously with changing syn_in -> jobs accepted only in IDLE, one done per 14 cycles, each result matches syndromes at its acceptance edge.
